// File: rtl/uart_fpga_rx_os_fifo.sv
// 16x oversampled UART receiver with majority-vote bit recovery and a show-ahead receive FIFO.
// Define UART_RX_BREAK_DETECT_EN to drop break frames and pulse OUT_RX_BREAK instead.
module uart_fpga_rx_os_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          IN_CLOCK,
    input  logic                          IN_RESET_N,
    input  logic                          IN_RX_SERIAL,
    input  logic [DIV_WIDTH-1:0]          IN_BAUD_DIV,
    output logic [DATA_BITS-1:0]          OUT_RX_DATA,
    output logic                          OUT_RX_PARITY_ERR,
    output logic                          OUT_RX_FRAME_ERR,
    output logic                          OUT_RX_VALID,
    input  logic                          IN_RX_READY,
    output logic [$clog2(FIFO_DEPTH):0]   OUT_RX_LEVEL,
    output logic                          OUT_RX_OVERRUN,
    output logic                          OUT_RX_BREAK
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = DATA_BITS + 2;
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_LINE_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta, rx_sync;
    logic [DIV_WIDTH-1:0]   div_q, tick_cnt;
    logic [3:0]             s_cnt, bit_cnt;
    logic                   samp7, samp8, line_hi;
    logic                   perr_q, ferr_q, pbit_q;
    logic [DATA_BITS-1:0]   shreg;
    logic                   push_q, overrun_q, brk_q;
    logic [WW-1:0]          push_word;
    logic [WW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [LW-1:0]          count;
    logic                   tick, dec_tick, end_tick, maj, ferr_now, is_break;
    logic                   push_now, brk_now, pop, full, wr_en;
    logic [WW-1:0]          head;

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= IN_RX_SERIAL;
            rx_sync <= rx_meta;
        end
    end

    assign tick     = (state_q != ST_IDLE) && (tick_cnt == div_q);
    assign dec_tick = tick && (s_cnt == 4'd9);
    assign end_tick = tick && (s_cnt == 4'd15);
    assign maj      = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);
    assign ferr_now = ferr_q | ~maj;
    assign is_break = (shreg == '0) && !pbit_q && ferr_now;

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        push_now = 1'b0;
        brk_now  = 1'b0;
        case (state_q)
            ST_IDLE:      if (!rx_sync) state_d = ST_START;
            ST_START: begin
                if (dec_tick && maj) state_d = ST_IDLE;
                else if (end_tick)   state_d = ST_DATA;
            end
            ST_DATA:      if (end_tick && bit_cnt == LAST_DATA)
                              state_d = (PARITY == 0) ? ST_STOP : ST_PARITY;
            ST_PARITY:    if (end_tick) state_d = ST_STOP;
            ST_STOP: begin
                // The frame completes on the last stop decision so a new start edge is caught early.
                if (dec_tick && bit_cnt == LAST_STOP) begin
                    if (BRK_EN && is_break) begin
                        brk_now = 1'b1;
                        state_d = ST_LINE_WAIT;
                    end else begin
                        push_now = 1'b1;
                        state_d  = ferr_now ? ST_LINE_WAIT : ST_IDLE;
                    end
                end
            end
            ST_LINE_WAIT: if (tick && line_hi && rx_sync) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            tick_cnt <= '0;
            s_cnt    <= '0;
            div_q    <= '0;
        end else if (state_q == ST_IDLE) begin
            tick_cnt <= '0;
            s_cnt    <= '0;
            if (!rx_sync) div_q <= IN_BAUD_DIV;
        end else if (tick) begin
            tick_cnt <= '0;
            s_cnt    <= s_cnt + 4'd1;
        end else begin
            tick_cnt <= tick_cnt + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            bit_cnt <= '0;
            samp7   <= 1'b1;
            samp8   <= 1'b1;
            line_hi <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pbit_q  <= 1'b0;
            push_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            push_q <= push_now;
            brk_q  <= brk_now;
            if (state_q != state_d) bit_cnt <= '0;
            else if (end_tick)      bit_cnt <= bit_cnt + 4'd1;
            if (tick && s_cnt == 4'd7) samp7 <= rx_sync;
            if (tick && s_cnt == 4'd8) samp8 <= rx_sync;
            if (state_q != ST_LINE_WAIT) line_hi <= 1'b0;
            else if (!rx_sync)           line_hi <= 1'b0;
            else if (tick)               line_hi <= 1'b1;
            if (state_q == ST_IDLE) begin
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
                pbit_q <= 1'b0;
            end else if (state_q == ST_PARITY && dec_tick) begin
                pbit_q <= maj;
                perr_q <= (PARITY == 2) ? ~(^shreg ^ maj) : (^shreg ^ maj);
            end else if (state_q == ST_STOP && dec_tick && !maj) begin
                ferr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge IN_CLOCK) begin
        if (state_q == ST_DATA && dec_tick) shreg <= {maj, shreg[DATA_BITS-1:1]};
        if (push_now) push_word <= {shreg, perr_q, ferr_now};
    end

    // Receive FIFO: a push arriving when full is only accepted if the head leaves the same cycle.
    assign pop   = OUT_RX_VALID & IN_RX_READY;
    assign full  = (count == FULL_LVL);
    assign wr_en = push_q & (~full | pop);

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push_q & full & ~pop;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge IN_CLOCK) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    assign head              = mem[rd_ptr];
    assign OUT_RX_VALID      = (count != '0);
    assign OUT_RX_DATA       = OUT_RX_VALID ? head[WW-1:2] : '0;
    assign OUT_RX_PARITY_ERR = OUT_RX_VALID & head[1];
    assign OUT_RX_FRAME_ERR  = OUT_RX_VALID & head[0];
    assign OUT_RX_LEVEL      = count;
    assign OUT_RX_OVERRUN    = overrun_q;
    assign OUT_RX_BREAK      = brk_q;

endmodule
